interrupt_requester: RTL and testbench
======================================

Name: interrupt_requester

Overview:
- Requesting end of the core's interrupt request/acknowledge handshake.
- Captures rising edges on NUM_SRC device interrupt lines into pending bits and selects the highest-priority enabled source.
- Raises interrupt_request with a stable irq_id and holds it until interrupt_acknowledge is seen.
- Blocks further requests until the handler signals completion on interrupt_done. No nesting.

Parameters:
- NUM_SRC, 8, number of device interrupt lines.
- ID_W, 3, width of irq_id; must equal $clog2(NUM_SRC).

Ports:
- clk  input  1  core clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- irq_src  input  NUM_SRC  device interrupt lines, synchronous to clk, level.
- irq_enable  input  NUM_SRC  per-source arbitration enable.
- global_enable  input  1  master interrupt enable.
- interrupt_acknowledge  input  1  registered acknowledge from the interrupt controller.
- interrupt_done  input  1  one-cycle pulse, handler return.
- interrupt_request  output  1  request to the interrupt controller.
- irq_id  output  ID_W  index of the source being requested or serviced.
- irq_pending  output  NUM_SRC  pending register, direct view.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; interrupt_request=0, irq_id=0, irq_pending=0, busy=0; edge-history register src_q=0.
  - A line already high at reset release therefore counts as one rising edge.
- Edge capture, every cycle in every state: pending[i] is set when irq_src[i]=1 and src_q[i]=0. Then src_q<=irq_src.
  - irq_enable does not gate capture; it only gates arbitration.
  - A held level produces exactly one pending set.
- Arbitration: the winner is the lowest index i with pending[i] & irq_enable[i]. Combinational; it is sampled only in IDLE.
- FSM:
  - IDLE: if global_enable=1, any enabled pending bit exists, and interrupt_acknowledge=0, then irq_id<=winner, interrupt_request<=1, go to REQ. Otherwise stay.
    - The ack=0 guard keeps a stale acknowledge from the previous service from being accepted.
  - REQ: hold interrupt_request=1 and irq_id stable. The request is never withdrawn, even if global_enable or irq_enable drops.
    - On interrupt_acknowledge=1: clear pending[irq_id], interrupt_request<=0, go to SERVICE.
  - SERVICE: interrupt_request=0 and irq_id held. interrupt_acknowledge is ignored.
    - On interrupt_done=1, go to IDLE. irq_id keeps its last value.
  - interrupt_done in IDLE or REQ is ignored.
- Latency with a registered-ack controller:
  - Edge sampled at posedge t0: pending set after t0.
  - interrupt_request=1 after t1.
  - Controller ack=1 after t2.
  - REQ→SERVICE and request=0 after t3.
  - Request is high for exactly 2 cycles.
- Simultaneous clear and set on the same bit (new edge in the ack cycle): set wins, so pending stays 1 and the new event is not lost.
- Edges arriving during REQ or SERVICE accumulate in pending and are arbitrated in the next IDLE.
- busy is combinational from state. interrupt_request and irq_id are registered.

Test Plan:
- Single edge: irq_enable=8'hFF, global_enable=1, pulse irq_src[3] at t0, controller model with registered ack. Required: irq_pending=8'h08 after t0; interrupt_request=1 for cycles t1–t3 only; irq_id=3; irq_pending=0 after t3; busy=1 until interrupt_done, then 0.
- Priority: rising edges on irq_src[5] and irq_src[2] in the same cycle. Required: first request has irq_id=2 with pending=8'h20 remaining; after interrupt_done, a second request has irq_id=5; pending ends at 0.
- Masking: irq_enable[4]=0, edge on irq_src[4]. Required: irq_pending=8'h10, no request for 20 cycles. Set irq_enable[4]=1: request with irq_id=4 on the next cycle.
- Level and set-wins:
  - Hold irq_src[1]=1 for 50 cycles: exactly one request.
  - Separately, raise irq_src[6] in the same cycle REQ samples ack for id 6: pending[6] stays 1, and a second id-6 request follows done.
- Stale ack: keep interrupt_acknowledge=1 while interrupt_done pulses with a source pending. Required: interrupt_request stays 0 until ack goes 0, then asserts next cycle.
- Reset mid-service: assert reset_n=0 in SERVICE with pending=8'h81. Required: all outputs 0 immediately (asynchronously). Release with irq_src[0] held high: one request with irq_id=0.

Source files
------------

// File: rtl/interrupt_requester.sv
// Requesting side of the core interrupt request/acknowledge handshake.
// Captures rising edges into pending bits, arbitrates by lowest index, and serves one at a time.
module interrupt_requester #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_enable,
    input  logic               global_enable,
    input  logic               interrupt_acknowledge,
    input  logic               interrupt_done,
    output logic               interrupt_request,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] irq_pending,
    output logic               busy
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] enabled;
    logic               any_enabled;
    logic [ID_W-1:0]    winner;

    always_comb begin
        rise        = irq_src & ~src_q;
        enabled     = pending_q & irq_enable;
        any_enabled = |enabled;
    end

    // Scan downwards so the lowest enabled index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        id_d      = id_q;
        pending_d = pending_q;

        unique case (state_q)
            StIdle: begin
                // A lingering acknowledge from the last service must not complete a new request.
                if (global_enable && any_enabled && !interrupt_acknowledge) begin
                    id_d    = winner;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (interrupt_acknowledge) begin
                    pending_d[id_q] = 1'b0;
                    req_d           = 1'b0;
                    state_d         = StService;
                end
            end
            StService: begin
                if (interrupt_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase

        // Applied after the clear so an edge in the acknowledge cycle is not lost.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            src_q     <= '0;
            pending_q <= '0;
            req_q     <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= irq_src;
            pending_q <= pending_d;
            req_q     <= req_d;
            id_q      <= id_d;
        end
    end

    assign interrupt_request = req_q;
    assign irq_id            = id_q;
    assign irq_pending       = pending_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_interrupt_requester.sv
// Directed and randomized checks of interrupt_requester against a cycle-level behavioural model.
module tb_interrupt_requester;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] irq_enable;
    logic               global_enable;
    logic               interrupt_acknowledge;
    logic               interrupt_done;
    logic               interrupt_request;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] irq_pending;
    logic               busy;

    always #5 clk = ~clk;

    interrupt_requester #(
        .NUM_SRC(NUM_SRC),
        .ID_W   (ID_W)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .irq_src              (irq_src),
        .irq_enable           (irq_enable),
        .global_enable        (global_enable),
        .interrupt_acknowledge(interrupt_acknowledge),
        .interrupt_done       (interrupt_done),
        .interrupt_request    (interrupt_request),
        .irq_id               (irq_id),
        .irq_pending          (irq_pending),
        .busy                 (busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit auto_ack    = 1'b1;

    // Model: phase 0 = idle, 1 = requesting, 2 = being serviced.
    bit m_pend[NUM_SRC];
    bit m_hist[NUM_SRC];
    int m_phase;
    int m_id;

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            m_pend[i] = 1'b0;
            m_hist[i] = 1'b0;
        end
        m_phase = 0;
        m_id    = 0;
    endtask

    function automatic logic [NUM_SRC-1:0] model_pend();
        logic [NUM_SRC-1:0] v;
        for (int i = 0; i < NUM_SRC; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_clock();
        bit rise[NUM_SRC];
        int w;
        for (int i = 0; i < NUM_SRC; i++) rise[i] = irq_src[i] && !m_hist[i];
        if (m_phase == 0) begin
            w = -1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w < 0 && m_pend[i] && irq_enable[i]) w = i;
            end
            if (global_enable && !interrupt_acknowledge && w >= 0) begin
                m_id    = w;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (interrupt_acknowledge) begin
                m_pend[m_id] = 1'b0;
                m_phase      = 2;
            end
        end else begin
            if (interrupt_done) m_phase = 0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rise[i]) m_pend[i] = 1'b1;
            m_hist[i] = irq_src[i];
        end
    endtask

    task automatic check(string tag);
        logic [ID_W+NUM_SRC+1:0] exp_v;
        logic [ID_W+NUM_SRC+1:0] obs_v;
        exp_v = {m_phase == 1, ID_W'(m_id), model_pend(), m_phase != 0};
        obs_v = {interrupt_request, irq_id, irq_pending, busy};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: {req,id,pend,busy} observed %h expected %h", tag, obs_v, exp_v);
        end
    endtask

    task automatic expect_eq(string tag, logic [31:0] obs, logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Registered-ack controller: ack after an edge equals the request seen before it.
    task automatic step(string tag);
        bit prev_req;
        @(posedge clk);
        prev_req = (m_phase == 1);
        model_clock();
        #1;
        check(tag);
        if (auto_ack) interrupt_acknowledge = prev_req;
    endtask

    task automatic run(int n, string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic done_pulse();
        interrupt_done = 1'b1;
        step("done");
        interrupt_done = 1'b0;
    endtask

    initial begin
        int nreq;
        bit prev;

        reset_n               = 1'b0;
        irq_src               = '0;
        irq_enable            = 8'hFF;
        global_enable         = 1'b1;
        interrupt_acknowledge = 1'b0;
        interrupt_done        = 1'b0;
        model_reset();
        #1;
        check("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Single edge on source 3
        irq_src = 8'h08;
        step("single_t0");
        expect_eq("single_pend", 32'(irq_pending), 32'h08);
        irq_src = 8'h00;
        step("single_t1");
        expect_eq("single_req_t1", 32'(interrupt_request), 1);
        expect_eq("single_id", 32'(irq_id), 3);
        step("single_t2");
        expect_eq("single_req_t2", 32'(interrupt_request), 1);
        step("single_t3");
        expect_eq("single_req_t3", 32'(interrupt_request), 0);
        expect_eq("single_pend_clr", 32'(irq_pending), 0);
        run(3, "single_svc");
        expect_eq("single_busy", 32'(busy), 1);
        done_pulse();
        expect_eq("single_idle", 32'(busy), 0);

        // Priority between sources 5 and 2
        irq_src = 8'h24;
        step("prio_t0");
        irq_src = 8'h00;
        run(3, "prio_first");
        expect_eq("prio_id2", 32'(irq_id), 2);
        expect_eq("prio_pend20", 32'(irq_pending), 32'h20);
        done_pulse();
        step("prio_second");
        expect_eq("prio_req5", 32'(interrupt_request), 1);
        expect_eq("prio_id5", 32'(irq_id), 5);
        run(2, "prio_svc");
        expect_eq("prio_pend0", 32'(irq_pending), 0);
        done_pulse();

        // Masked source 4
        irq_enable = 8'hEF;
        irq_src    = 8'h10;
        step("mask_t0");
        irq_src = 8'h00;
        run(20, "mask_wait");
        expect_eq("mask_pend", 32'(irq_pending), 32'h10);
        expect_eq("mask_noreq", 32'(interrupt_request), 0);
        irq_enable = 8'hFF;
        step("mask_enable");
        expect_eq("mask_req", 32'(interrupt_request), 1);
        expect_eq("mask_id4", 32'(irq_id), 4);
        run(3, "mask_svc");
        done_pulse();

        // Held level on source 1 gives one request
        nreq = 0;
        prev = interrupt_request;
        irq_src = 8'h02;
        for (int i = 0; i < 50; i++) begin
            interrupt_done = (i == 10);
            step("level");
            if (interrupt_request && !prev) nreq++;
            prev = interrupt_request;
        end
        interrupt_done = 1'b0;
        irq_src        = 8'h00;
        expect_eq("level_one_req", 32'(nreq), 1);
        step("level_end");

        // New edge on source 6 in its own acknowledge cycle
        irq_src = 8'h40;
        step("setwin_t0");
        irq_src = 8'h00;
        run(2, "setwin_req");
        irq_src = 8'h40;
        step("setwin_ack");
        expect_eq("setwin_pend", 32'(irq_pending), 32'h40);
        expect_eq("setwin_busy", 32'(busy), 1);
        irq_src = 8'h00;
        step("setwin_svc");
        done_pulse();
        step("setwin_again");
        expect_eq("setwin_req6", 32'(interrupt_request), 1);
        expect_eq("setwin_id6", 32'(irq_id), 6);
        run(3, "setwin_svc2");
        done_pulse();

        // Stale acknowledge held across done
        auto_ack = 1'b0;
        irq_src  = 8'h01;
        step("stale_t0");
        irq_src = 8'h00;
        step("stale_req");
        interrupt_acknowledge = 1'b1;
        step("stale_ack");
        irq_src = 8'h08;
        step("stale_edge");
        irq_src = 8'h00;
        done_pulse();
        run(3, "stale_hold");
        expect_eq("stale_noreq", 32'(interrupt_request), 0);
        interrupt_acknowledge = 1'b0;
        step("stale_release");
        expect_eq("stale_req", 32'(interrupt_request), 1);
        expect_eq("stale_id3", 32'(irq_id), 3);
        interrupt_acknowledge = 1'b1;
        step("stale_ack2");
        interrupt_acknowledge = 1'b0;
        done_pulse();
        auto_ack = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            irq_src       = irq_src ^ NUM_SRC'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) irq_enable = NUM_SRC'($urandom);
            global_enable  = ($urandom_range(0, 7) != 0);
            interrupt_done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                auto_ack              = 1'b0;
                interrupt_acknowledge = 1'($urandom_range(0, 1));
            end else begin
                auto_ack = 1'b1;
            end
            step("rand");
        end

        // Drain to idle, then reset in the middle of a service
        irq_src        = 8'h00;
        irq_enable     = 8'hFF;
        global_enable  = 1'b1;
        interrupt_done = 1'b0;
        auto_ack       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            interrupt_done = (i % 4 == 3);
            step("drain");
        end
        interrupt_done = 1'b0;
        while (m_phase != 0) done_pulse();
        for (int i = 0; i < 8; i++) begin
            if (m_phase == 2) done_pulse();
            else step("drain2");
        end
        while (m_phase != 0) done_pulse();
        interrupt_acknowledge = 1'b0;
        step("drain3");
        for (int i = 0; i < 16 && model_pend() != 0; i++) begin
            if (m_phase == 2) done_pulse();
            else step("drain4");
        end
        while (m_phase != 0) done_pulse();

        irq_src = 8'h81;
        step("rst_t0");
        irq_src = 8'h00;
        run(3, "rst_req");
        irq_src = 8'h01;
        step("rst_reedge");
        expect_eq("rst_pend81", 32'(irq_pending), 32'h81);
        expect_eq("rst_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async");
        expect_eq("rst_pend0", 32'(irq_pending), 0);
        expect_eq("rst_busy0", 32'(busy), 0);
        interrupt_acknowledge = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        nreq    = 0;
        prev    = 1'b0;
        for (int i = 0; i < 15; i++) begin
            interrupt_done = (i == 8);
            step("rst_level");
            if (interrupt_request && !prev) begin
                nreq++;
                expect_eq("rst_id0", 32'(irq_id), 0);
            end
            prev = interrupt_request;
        end
        interrupt_done = 1'b0;
        expect_eq("rst_one_req", 32'(nreq), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
